fpga_link_transmitter: RTL and testbench
========================================

Name: fpga_link_transmitter

Overview:
- Parametrised serial transmitter for FPGA-to-FPGA links; next generation of the 8-bit transmitter.
- Accepts parallel words from local logic over a valid/ready interface. Each word is sent to the peer FPGA MSB-first, one bit per clock.
- Uses a four-phase request/acknowledge handshake plus a peer "received" confirmation.
- Adds: configurable width, burst framing via tx_last, handshake timeout with error flag, wrap-around word counter, optional parity.

Parameters:
- DATA_WIDTH, 8, bits per word (>=2).
- ACK_TIMEOUT, 255, max cycles waiting in REQ or WAIT_DONE before abort (>=1).
- COUNT_WIDTH, 16, width of words_sent counter.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_valid  in  1  local word available.
- tx_ready  out  1  block can accept a word (high only in IDLE).
- tx_data  in  DATA_WIDTH  word to send.
- tx_last  in  1  word is last of burst; sampled with tx_data.
- send_to_other  out  1  request line to peer.
- acknowledge  in  1  peer ready to receive.
- data_out  out  1  serial bit to peer.
- bit_valid  out  1  data_out carries a valid bit this cycle.
- sent  in  1  peer confirms full word received.
- finish  out  1  one-cycle pulse: word completed successfully.
- finish_sent  out  1  one-cycle pulse coincident with finish when the word had tx_last=1.
- error  out  1  one-cycle pulse on timeout abort.
- words_sent  out  COUNT_WIDTH  count of successfully finished words.

Behaviour:
- Reset, synchronous, checked first, overrides everything:
  - state=IDLE; shift register, bit counter, timeout counter and words_sent = 0.
  - send_to_other=0, data_out=0, bit_valid=0, finish=0, finish_sent=0, error=0.
  - tx_ready=1 in the first cycle after reset.
- Reset mid-transfer abandons the word; no finish or error pulse is issued.
- States: IDLE, REQ, SHIFT, PARITY (only with the macro), WAIT_DONE, RELEASE.
- IDLE:
  - tx_ready=1.
  - On tx_valid&tx_ready: latch tx_data into the shift register and tx_last into a flag. Clear the timeout counter. Next state REQ.
- REQ:
  - send_to_other=1.
  - acknowledge=1 -> SHIFT with bit counter=0.
  - Otherwise the timeout counter increments. When it reaches ACK_TIMEOUT-1 with acknowledge still 0 -> error pulse next cycle, go to IDLE, send_to_other drops.
- SHIFT:
  - send_to_other=1, bit_valid=1.
  - data_out = shift register MSB; the first SHIFT cycle carries tx_data[DATA_WIDTH-1].
  - Shift left, zero-fill, each cycle; exactly DATA_WIDTH cycles.
  - After the last bit -> PARITY if enabled, else WAIT_DONE. The timeout counter is cleared on exit.
  - acknowledge is ignored during SHIFT.
- WAIT_DONE:
  - send_to_other=1, bit_valid=0, data_out=0.
  - sent=1 -> RELEASE. In the transition cycle, register finish=1, finish_sent=tx_last flag and words_sent+1, all visible the next cycle.
  - Timeout as in REQ -> error, IDLE, words_sent unchanged.
- RELEASE:
  - send_to_other=0.
  - Wait until acknowledge=0 and sent=0 (four-phase completion), then IDLE. No timeout in this state.
- words_sent wraps from 2^COUNT_WIDTH-1 to 0 silently.
- Latency from tx_valid acceptance (peer acknowledge already high):
  - send_to_other rises 1 cycle later.
  - First bit_valid 2 cycles later.
  - Last bit at cycle DATA_WIDTH+1.
- finish and error are never high in the same cycle.
- tx_data and tx_last are sampled only at acceptance; later changes have no effect.

Optional Feature:
- Macro FPGA_LINK_PARITY_EN.
- Defined:
  - PARITY state adds one cycle after SHIFT with bit_valid=1.
  - data_out = even parity (XOR-reduce) of the latched word.
  - Frame length is DATA_WIDTH+1 bits.
- Undefined: PARITY state and its logic are absent; frame length is DATA_WIDTH bits.

Test Plan:
- Reset, then DATA_WIDTH=8, tx_data=8'hA5, tx_last=1, peer acknowledge immediately, sent 2 cycles after the last bit -> serial bits 1,0,1,0,0,1,0,1 on bit_valid cycles; finish=1 and finish_sent=1 for one cycle; words_sent=1; send_to_other low until acknowledge and sent drop.
- Burst of 3 words 8'h01, 8'h80, 8'hFF with tx_last only on the third -> finish pulses 3 times, finish_sent only on the third; words_sent=3.
- ACK_TIMEOUT=4, acknowledge held 0 -> error pulse after 4 REQ cycles, no bits shifted, tx_ready=1 afterwards, words_sent unchanged.
- Assert reset during the 4th SHIFT cycle -> next cycle all outputs 0, tx_ready=1, no finish or error; a fresh word 8'h3C transmits correctly afterwards.
- COUNT_WIDTH=2, send 5 words -> words_sent sequence 1,2,3,0,1.
- With FPGA_LINK_PARITY_EN, tx_data=8'h07 -> 9 bit_valid cycles, ninth bit=1; 8'h03 -> ninth bit=0.

Source files
------------

// File: rtl/fpga_link_transmitter.sv
// fpga_link_transmitter: MSB-first serial word transmitter with four-phase request/acknowledge
// handshake, burst framing, timeout abort and optional even-parity bit (define FPGA_LINK_PARITY_EN).
module fpga_link_transmitter #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [DATA_WIDTH-1:0]  tx_data,
    input  logic                   tx_last,
    output logic                   send_to_other,
    input  logic                   acknowledge,
    output logic                   data_out,
    output logic                   bit_valid,
    input  logic                   sent,
    output logic                   finish,
    output logic                   finish_sent,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] words_sent
);

    localparam int BCW = $clog2(DATA_WIDTH);
    localparam int TCW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SHIFT,
`ifdef FPGA_LINK_PARITY_EN
        ST_PARITY,
`endif
        ST_WAIT_DONE,
        ST_RELEASE
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TCW-1:0]         tmo_q, tmo_d;
    logic [COUNT_WIDTH-1:0] words_q, words_d;
    logic                   last_q, last_d;
    logic                   finish_q, finish_d;
    logic                   finish_sent_q, finish_sent_d;
    logic                   error_q, error_d;
`ifdef FPGA_LINK_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            tmo_q         <= '0;
            words_q       <= '0;
            last_q        <= 1'b0;
            finish_q      <= 1'b0;
            finish_sent_q <= 1'b0;
            error_q       <= 1'b0;
`ifdef FPGA_LINK_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            tmo_q         <= tmo_d;
            words_q       <= words_d;
            last_q        <= last_d;
            finish_q      <= finish_d;
            finish_sent_q <= finish_sent_d;
            error_q       <= error_d;
`ifdef FPGA_LINK_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        tmo_d         = tmo_q;
        words_d       = words_q;
        last_d        = last_q;
        finish_d      = 1'b0;
        finish_sent_d = 1'b0;
        error_d       = 1'b0;
`ifdef FPGA_LINK_PARITY_EN
        parity_d      = parity_q;
`endif
        tx_ready      = 1'b0;
        send_to_other = 1'b0;
        bit_valid     = 1'b0;
        data_out      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    shift_d = tx_data;
                    last_d  = tx_last;
                    tmo_d   = '0;
`ifdef FPGA_LINK_PARITY_EN
                    parity_d = ^tx_data;
`endif
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                send_to_other = 1'b1;
                if (acknowledge) begin
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TCW'(1);
                end
            end

            ST_SHIFT: begin
                send_to_other = 1'b1;
                bit_valid     = 1'b1;
                data_out      = shift_q[DATA_WIDTH-1];
                shift_d       = {shift_q[DATA_WIDTH-2:0], 1'b0};
                bit_cnt_d     = bit_cnt_q + BCW'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    tmo_d = '0;
`ifdef FPGA_LINK_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_WAIT_DONE;
`endif
                end
            end

`ifdef FPGA_LINK_PARITY_EN
            ST_PARITY: begin
                // Parity comes from the word as accepted; the shift register is zero by now.
                send_to_other = 1'b1;
                bit_valid     = 1'b1;
                data_out      = parity_q;
                state_d       = ST_WAIT_DONE;
            end
`endif

            ST_WAIT_DONE: begin
                send_to_other = 1'b1;
                if (sent) begin
                    finish_d      = 1'b1;
                    finish_sent_d = last_q;
                    words_d       = words_q + COUNT_WIDTH'(1);
                    state_d       = ST_RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TCW'(1);
                end
            end

            ST_RELEASE: begin
                // Four-phase completion: peer must drop both lines before the next word.
                if (!acknowledge && !sent) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign finish      = finish_q;
    assign finish_sent = finish_sent_q;
    assign error       = error_q;
    assign words_sent  = words_q;

endmodule

// File: tb/tb_fpga_link_transmitter.sv
// Directed bench for fpga_link_transmitter: per-cycle expectations built from the protocol
// phase timeline of each word, plus literal checks of serial bits, pulse counts and word counts.
module tb_fpga_link_transmitter;

    localparam int DW = 8;
    localparam int AT = 4;
    localparam int CW = 2;
`ifdef FPGA_LINK_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_last;
    logic          send_to_other;
    logic          acknowledge;
    logic          data_out;
    logic          bit_valid;
    logic          sent;
    logic          finish;
    logic          finish_sent;
    logic          error;
    logic [CW-1:0] words_sent;

    always #5 clk = ~clk;

    fpga_link_transmitter #(
        .DATA_WIDTH (DW),
        .ACK_TIMEOUT(AT),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .send_to_other(send_to_other),
        .acknowledge  (acknowledge),
        .data_out     (data_out),
        .bit_valid    (bit_valid),
        .sent         (sent),
        .finish       (finish),
        .finish_sent  (finish_sent),
        .error        (error),
        .words_sent   (words_sent)
    );

    // Model state: pulses due next cycle and the expected word count.
    logic [CW-1:0] words_exp;
    logic          p_fin, p_fs, p_err;

    int n_vec, n_miss, cyc_n;
    int nbits, n_fin, n_fs, n_err;
    logic [15:0]   bits_cap;
    logic [CW-1:0] words_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs already driven, compare at the falling edge, log observed activity.
    task automatic tick(input logic e_rdy, input logic e_sto, input logic e_dout, input logic e_bv);
        logic [31:0] e, a;
        e = 32'({e_rdy, e_sto, e_dout, e_bv, p_fin, p_fs, p_err, words_exp});
        p_fin = 1'b0;
        p_fs  = 1'b0;
        p_err = 1'b0;
        @(negedge clk);
        a = 32'({tx_ready, send_to_other, data_out, bit_valid, finish, finish_sent, error, words_sent});
        check($sformatf("cycle %0d outputs", cyc_n), a, e);
        if (bit_valid === 1'b1) begin
            bits_cap = {bits_cap[14:0], data_out};
            nbits++;
        end
        if (finish === 1'b1) begin
            n_fin++;
            words_log.push_back(words_sent);
        end
        if (finish_sent === 1'b1) n_fs++;
        if (error === 1'b1) n_err++;
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset       = 1'b1;
        tx_valid    = 1'b0;
        tx_data     = '0;
        tx_last     = 1'b0;
        acknowledge = 1'b0;
        sent        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        words_exp = '0;
        p_fin     = 1'b0;
        p_fs      = 1'b0;
        p_err     = 1'b0;
    endtask

    task automatic accept(input logic [DW-1:0] d, input logic last, input logic ack);
        tx_valid    = 1'b1;
        tx_data     = d;
        tx_last     = last;
        acknowledge = ack;
        sent        = 1'b0;
        tick(1, 0, 0, 0);
        tx_valid = 1'b0;
        tx_data  = ~d;
        tx_last  = ~last;
    endtask

    task automatic shift_frame(input logic [DW-1:0] d);
        for (int i = 0; i < DW; i++) begin
            acknowledge = (i % 3 != 1);
            tick(0, 1, d[DW-1-i], 1);
        end
`ifdef FPGA_LINK_PARITY_EN
        tick(0, 1, ^d, 1);
`endif
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last,
                             input int ack_wait, input int sent_gap, input int rel_gap);
        accept(d, last, ack_wait == 0);
        for (int i = 0; i < ack_wait; i++) begin
            acknowledge = 1'b0;
            tick(0, 1, 0, 0);
        end
        acknowledge = 1'b1;
        tick(0, 1, 0, 0);
        shift_frame(d);
        acknowledge = 1'b1;
        sent        = 1'b0;
        for (int i = 0; i < sent_gap; i++) tick(0, 1, 0, 0);
        sent = 1'b1;
        tick(0, 1, 0, 0);
        p_fin     = 1'b1;
        p_fs      = last;
        words_exp = words_exp + CW'(1);
        for (int i = 0; i < rel_gap; i++) begin
            acknowledge = (i == 0);
            sent        = 1'b1;
            tick(0, 0, 0, 0);
        end
        acknowledge = 1'b0;
        sent        = 1'b0;
        tick(0, 0, 0, 0);
    endtask

    task automatic req_timeout(input logic [DW-1:0] d);
        accept(d, 1'b0, 1'b0);
        for (int i = 0; i < AT; i++) tick(0, 1, 0, 0);
        p_err = 1'b1;
    endtask

    task automatic wait_timeout(input logic [DW-1:0] d);
        accept(d, 1'b1, 1'b1);
        tick(0, 1, 0, 0);
        shift_frame(d);
        acknowledge = 1'b1;
        sent        = 1'b0;
        for (int i = 0; i < AT; i++) tick(0, 1, 0, 0);
        p_err       = 1'b1;
        acknowledge = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nb0, f0, fs0, e0;
        logic [7:0] wbits;
        logic [8:0] pbits;
        logic [CW-1:0] wrap_exp[5];
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        n_vec = 0; n_miss = 0; cyc_n = 0;
        nbits = 0; n_fin = 0; n_fs = 0; n_err = 0;
        bits_cap = '0;

        reset_dut();
        tick(1, 0, 0, 0);

        // Single word 0xA5 marked last, sent confirmed two cycles after the last bit.
        nb0 = nbits; f0 = n_fin; fs0 = n_fs;
        send_word(8'hA5, 1'b1, 0, 1, 1);
        wbits = 8'(bits_cap >> PB);
        check("A5 serial bits", 32'(wbits), 32'h0000_00A5);
        check("A5 bit count", 32'(nbits - nb0), 32'(8 + PB));
        check("A5 finish pulses", 32'(n_fin - f0), 32'd1);
        check("A5 finish_sent pulses", 32'(n_fs - fs0), 32'd1);
        check("A5 words_sent", 32'(words_sent), 32'd1);
        tick(1, 0, 0, 0);

        // Burst of three with tx_last only on the final word.
        reset_dut();
        f0 = n_fin; fs0 = n_fs;
        send_word(8'h01, 1'b0, 0, 0, 0);
        send_word(8'h80, 1'b0, 1, 1, 0);
        send_word(8'hFF, 1'b1, 2, 3, 3);
        check("burst finish pulses", 32'(n_fin - f0), 32'd3);
        check("burst finish_sent pulses", 32'(n_fs - fs0), 32'd1);
        check("burst words_sent", 32'(words_sent), 32'd3);
        tick(1, 0, 0, 0);

        // Acknowledge never arrives; then sent never arrives.
        nb0 = nbits; e0 = n_err;
        req_timeout(8'h55);
        tick(1, 0, 0, 0);
        check("req timeout error pulses", 32'(n_err - e0), 32'd1);
        check("req timeout bits shifted", 32'(nbits - nb0), 32'd0);
        check("req timeout words_sent", 32'(words_sent), 32'd3);
        wait_timeout(8'hC3);
        tick(1, 0, 0, 0);
        check("wait timeout error pulses", 32'(n_err - e0), 32'd2);
        check("wait timeout words_sent", 32'(words_sent), 32'd3);

        // Reset asserted during the fourth SHIFT cycle, then a clean word.
        f0 = n_fin; e0 = n_err;
        accept(8'h96, 1'b1, 1'b1);
        tick(0, 1, 0, 0);
        tick(0, 1, 1, 1);
        tick(0, 1, 0, 1);
        tick(0, 1, 0, 1);
        reset = 1'b1;
        tick(0, 1, 1, 1);
        reset     = 1'b0;
        words_exp = '0;
        tick(1, 0, 0, 0);
        check("mid reset finish pulses", 32'(n_fin - f0), 32'd0);
        check("mid reset error pulses", 32'(n_err - e0), 32'd0);
        send_word(8'h3C, 1'b1, 0, 0, 1);
        wbits = 8'(bits_cap >> PB);
        check("3C serial bits", 32'(wbits), 32'h0000_003C);
        check("3C words_sent", 32'(words_sent), 32'd1);

        // Counter wrap with a 2-bit words_sent.
        reset_dut();
        words_log.delete();
        send_word(8'h11, 1'b0, 0, 0, 0);
        send_word(8'h22, 1'b0, 0, 1, 0);
        send_word(8'h44, 1'b0, 1, 0, 0);
        send_word(8'h88, 1'b0, 0, 0, 1);
        send_word(8'hF0, 1'b1, 0, 0, 0);
        check("wrap finish count", 32'(words_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < words_log.size(); i++)
            check($sformatf("wrap words_sent %0d", i), 32'(words_log[i]), 32'(wrap_exp[i]));

        // Parity framing.
        nb0 = nbits;
        send_word(8'h07, 1'b0, 0, 0, 0);
        pbits = bits_cap[8:0];
`ifdef FPGA_LINK_PARITY_EN
        check("07 frame bits", 32'(pbits), 32'({8'h07, 1'b1}));
        check("07 bit count", 32'(nbits - nb0), 32'd9);
`else
        check("07 frame bits", 32'(pbits[7:0]), 32'h0000_0007);
        check("07 bit count", 32'(nbits - nb0), 32'd8);
`endif
        nb0 = nbits;
        send_word(8'h03, 1'b1, 0, 0, 0);
        pbits = bits_cap[8:0];
`ifdef FPGA_LINK_PARITY_EN
        check("03 frame bits", 32'(pbits), 32'({8'h03, 1'b0}));
        check("03 bit count", 32'(nbits - nb0), 32'd9);
`else
        check("03 frame bits", 32'(pbits[7:0]), 32'h0000_0003);
        check("03 bit count", 32'(nbits - nb0), 32'd8);
`endif
        tick(1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
